// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-back cache with per-way LRU ages,
// single-word next-level transfers and a full-array flush walk.
module assoc_cache #(
  parameter int SETS      = 16,
  parameter int WAYS      = 2,
  parameter int LINEWORDS = 4,
  parameter int WORDWIDTH = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bus_request,
  input  logic                 bus_write,
  input  logic [ADDRWIDTH-1:0] bus_addr,
  input  logic [WORDWIDTH-1:0] bus_wdata,
  output logic [WORDWIDTH-1:0] bus_rdata,
  output logic                 bus_valid,
  input  logic                 flush_request,
  output logic                 flush_done,
  output logic                 nl_request,
  output logic                 nl_write,
  output logic [ADDRWIDTH-1:0] nl_addr,
  output logic [WORDWIDTH-1:0] nl_wdata,
  input  logic [WORDWIDTH-1:0] nl_rdata,
  input  logic                 nl_valid
);
  localparam int BW = $clog2(WORDWIDTH/8);
  localparam int WW = $clog2(LINEWORDS);
  localparam int SW = $clog2(SETS);
  localparam int AW = $clog2(WAYS);
  localparam int TW = ADDRWIDTH - SW - WW - BW;
  localparam int FW = SW + AW;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] FILL      = 3'd3;
  localparam logic [2:0] RESPOND   = 3'd4;
  localparam logic [2:0] FLUSH     = 3'd5;

  logic [2:0]                        state;
  logic [SETS-1:0][WAYS-1:0]         vld, dirty;
  logic [SETS-1:0][WAYS-1:0][AW-1:0] age;
  logic [TW-1:0]                     tags [SETS][WAYS];
  logic [WORDWIDTH-1:0]              data [SETS][WAYS][LINEWORDS];

  logic                 req_write;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [WORDWIDTH-1:0] req_wdata;
  logic [AW-1:0]        acc_way;   // hit way, or victim way on a miss
  logic [WW-1:0]        wcnt;      // word index of the current transfer
  logic [FW:0]          fl_idx;    // {done, set, way} flush walk position

  logic [TW-1:0] r_tag;
  logic [SW-1:0] r_set, fl_set, x_set;
  logic [WW-1:0] r_word;
  logic [AW-1:0] fl_way, x_way, hit_way, victim, inv_way, lru_way;
  logic          fl_end, fl_wb, hit, inv_found, ack, last;
  logic [TW-1:0] line_tag;
  logic          unused_addr;

  assign r_tag  = req_addr[ADDRWIDTH-1 -: TW];
  assign r_set  = req_addr[BW+WW +: SW];
  assign r_word = req_addr[BW +: WW];
  assign fl_set = fl_idx[FW-1:AW];
  assign fl_way = fl_idx[AW-1:0];
  assign fl_end = fl_idx[FW];
  assign unused_addr = ^req_addr;

  // Tag match and victim choice: lowest invalid way, else the oldest way
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld[r_set][AW'(w)] && tags[r_set][w] == r_tag && !hit) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
      if (!vld[r_set][AW'(w)] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
      if (age[r_set][AW'(w)] == AW'(WAYS-1)) lru_way = AW'(w);
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // Next-level port: the flush walk and miss handling share the word engine
  always_comb begin
    x_set    = (state == FLUSH) ? fl_set : r_set;
    x_way    = (state == FLUSH) ? fl_way : acc_way;
    line_tag = nl_write ? tags[x_set][x_way] : r_tag;
  end

  assign fl_wb      = (state == FLUSH) && !fl_end && vld[fl_set][fl_way] && dirty[fl_set][fl_way];
  assign nl_write   = (state == WRITEBACK) || fl_wb;
  assign nl_request = nl_write || (state == FILL);
  assign nl_addr    = nl_request ? (ADDRWIDTH'({line_tag, x_set, wcnt}) << BW) : '0;
  assign nl_wdata   = nl_write ? data[x_set][x_way][wcnt] : '0;
  assign ack        = nl_request && nl_valid;
  assign last       = (wcnt == WW'(LINEWORDS-1));

  assign bus_valid  = (state == RESPOND);
  assign bus_rdata  = bus_valid ? data[r_set][acc_way][r_word] : '0;
  // flush_done is a FLUSH-state cycle so a still-held flush_request is not re-taken
  assign flush_done = (state == FLUSH) && fl_end;

  // Control state, line status bits and LRU ages
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vld       <= '0;
      dirty     <= '0;
      acc_way   <= '0;
      wcnt      <= '0;
      fl_idx    <= '0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[SW'(s)][AW'(w)] <= AW'(w);
    end else begin
      case (state)
        IDLE: begin
          if (flush_request) begin
            state  <= FLUSH;
            fl_idx <= '0;
            wcnt   <= '0;
          end else if (bus_request) begin
            state     <= LOOKUP;
            req_write <= bus_write;
            req_addr  <= bus_addr;
            req_wdata <= bus_wdata;
          end
        end
        LOOKUP: begin
          wcnt <= '0;
          if (hit) begin
            acc_way <= hit_way;
            state   <= RESPOND;
          end else begin
            acc_way <= victim;
            state   <= (vld[r_set][victim] && dirty[r_set][victim]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (ack) begin
          wcnt <= wcnt + 1'b1;          // wraps to 0 for the fill
          if (last) state <= FILL;
        end
        FILL: if (ack) begin
          wcnt <= wcnt + 1'b1;
          if (last) begin
            vld[r_set][acc_way]   <= 1'b1;
            dirty[r_set][acc_way] <= 1'b0;
            state                 <= RESPOND;
          end
        end
        RESPOND: begin
          if (req_write) dirty[r_set][acc_way] <= 1'b1;
          // ages below the old age shift up by one; they can never pass WAYS-1
          for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == acc_way)
              age[r_set][AW'(w)] <= '0;
            else if (age[r_set][AW'(w)] < age[r_set][acc_way])
              age[r_set][AW'(w)] <= age[r_set][AW'(w)] + 1'b1;
          end
          state <= IDLE;
        end
        FLUSH: begin
          if (fl_end) begin
            state <= IDLE;
          end else if (fl_wb) begin
            if (ack) begin
              wcnt <= wcnt + 1'b1;
              if (last) begin
                dirty[fl_set][fl_way] <= 1'b0;
                fl_idx                <= fl_idx + 1'b1;
              end
            end
          end else begin
            fl_idx <= fl_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags; only written by fills and write responses
  always_ff @(posedge clock) begin
    if (state == FILL && ack) begin
      data[r_set][acc_way][wcnt] <= nl_rdata;
      if (last) tags[r_set][acc_way] <= r_tag;
    end
    if (state == RESPOND && req_write)
      data[r_set][acc_way][r_word] <= req_wdata;
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed scenarios plus random traffic against a
// recency-list cache model and a next-level memory responder.
module tb_assoc_cache;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_request = 1'b0, bus_write = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_valid;
  logic        flush_request = 1'b0;
  logic        flush_done;
  logic        nl_request, nl_write;
  logic [15:0] nl_addr;
  logic [31:0] nl_wdata;
  logic [31:0] nl_rdata = '0;
  logic        nl_valid = 1'b0;

  assoc_cache #(.SETS(4), .WAYS(2), .LINEWORDS(4), .WORDWIDTH(32), .ADDRWIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .bus_request(bus_request), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_valid(bus_valid),
    .flush_request(flush_request), .flush_done(flush_done),
    .nl_request(nl_request), .nl_write(nl_write), .nl_addr(nl_addr),
    .nl_wdata(nl_wdata), .nl_rdata(nl_rdata), .nl_valid(nl_valid)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  int stall_extra = 0, stab_err = 0, last_words = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // next-level memory (written by the DUT) and the model's own copy
  logic [31:0] nmem [16384];
  logic [31:0] rmem [16384];
  bit          act_w[$], exp_w[$];
  logic [15:0] act_a[$], exp_a[$];
  logic [31:0] act_d[$], exp_d[$];

  // Responder: each word completes 1+stall_extra cycles after its request appears
  initial begin : nl_resp
    int cnt; logic [15:0] ca; logic [31:0] cd; logic cw;
    cnt = 0; ca = '0; cd = '0; cw = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || !nl_request) begin
        nl_valid = 1'b0; cnt = 0;
      end else begin
        if (cnt == 0) begin ca = nl_addr; cd = nl_wdata; cw = nl_write; end
        else if (nl_addr !== ca || nl_write !== cw || nl_wdata !== cd) stab_err++;
        if (cnt >= 1 + stall_extra) begin
          nl_valid = 1'b1; cnt = 0;
          act_w.push_back(nl_write); act_a.push_back(nl_addr); act_d.push_back(nl_wdata);
          if (nl_write) nmem[nl_addr[15:2]] = nl_wdata;
          else nl_rdata = nmem[nl_addr[15:2]];
        end else begin
          nl_valid = 1'b0; cnt++;
        end
      end
    end
  end

  // Model: per set, resident lines in most-recent-first order
  typedef struct packed {
    logic [9:0]       tag;
    logic             dirty;
    logic [31:0]      way;
    logic [3:0][31:0] d;
  } line_t;
  line_t ml [4][2];
  int    mc [4];

  task automatic clear_q();
    act_w.delete(); act_a.delete(); act_d.delete();
    exp_w.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) mc[s] = 0;
  endtask

  task automatic model_wb(input int s, input line_t l);
    logic [15:0] a;
    for (int w = 0; w < 4; w++) begin
      a = {l.tag, 2'(s), 2'(w), 2'b00};
      exp_w.push_back(1'b1); exp_a.push_back(a); exp_d.push_back(l.d[w]);
      rmem[a[15:2]] = l.d[w];
    end
  endtask

  task automatic model_access(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output int words);
    int s, wi, hi, way; logic [9:0] t; line_t l; bit used[2]; logic [15:0] a;
    s = int'(addr[5:4]); t = addr[15:6]; wi = int'(addr[3:2]);
    hi = -1; words = 0; l = '0; way = 0;
    for (int i = 0; i < mc[s]; i++) if (ml[s][i].tag == t) hi = i;
    if (hi >= 0) begin
      l = ml[s][hi];
      for (int i = hi; i < mc[s] - 1; i++) ml[s][i] = ml[s][i+1];
      mc[s]--;
    end else begin
      if (mc[s] < 2) begin
        used = '{0, 0};
        for (int i = 0; i < mc[s]; i++) used[int'(ml[s][i].way)] = 1'b1;
        way = used[0] ? 1 : 0;
      end else begin
        l = ml[s][1]; mc[s]--; way = int'(l.way);
        if (l.dirty) begin model_wb(s, l); words += 4; end
      end
      l.tag = t; l.dirty = 1'b0; l.way = way;
      for (int w = 0; w < 4; w++) begin
        a = {t, 2'(s), 2'(w), 2'b00};
        l.d[w] = rmem[a[15:2]];
        exp_w.push_back(1'b0); exp_a.push_back(a); exp_d.push_back('0);
      end
      words += 4;
    end
    rd = l.d[wi];
    if (wr) begin l.d[wi] = wd; l.dirty = 1'b1; end
    for (int i = mc[s]; i > 0; i--) ml[s][i] = ml[s][i-1];
    ml[s][0] = l; mc[s]++;
  endtask

  task automatic model_flush(output int cyc);
    int k;
    cyc = 0;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        k = -1;
        for (int i = 0; i < mc[s]; i++) if (int'(ml[s][i].way) == w) k = i;
        if (k >= 0 && ml[s][k].dirty) begin
          model_wb(s, ml[s][k]); ml[s][k].dirty = 1'b0; cyc += 4 * (2 + stall_extra);
        end else cyc += 1;
      end
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, ".nops"}, act_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      chk({tag, ".nlwr"}, act_w[i], exp_w[i]);
      chk({tag, ".nladdr"}, act_a[i], exp_a[i]);
      if (exp_w[i]) chk({tag, ".nlwdata"}, act_d[i], exp_d[i]);
    end
    clear_q();
  endtask

  task automatic wait_for(input bit fl, output int lat);
    lat = 0;
    do begin @(negedge clock); lat++; end
    while (!(fl ? flush_done : bus_valid) && lat < 1000);
  endtask

  task automatic access(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wd, input bit now);
    logic [31:0] rd; int words, lat;
    model_access(wr, addr, wd, rd, words);
    if (!now) @(negedge clock);
    bus_request = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wd;
    wait_for(1'b0, lat);
    chk({tag, ".lat"}, lat, 2 + words * (2 + stall_extra));
    if (!wr) chk({tag, ".rdata"}, bus_rdata, rd);
    bus_request = 1'b0;
    chk_ops(tag);
    last_words = words;
  endtask

  task automatic flush(input string tag, input bit with_bus, input logic [15:0] addr);
    logic [31:0] rd; int words, lat, cyc;
    model_flush(cyc);
    @(negedge clock);
    flush_request = 1'b1;
    if (with_bus) begin bus_request = 1'b1; bus_write = 1'b0; bus_addr = addr; end
    wait_for(1'b1, lat);
    chk({tag, ".lat"}, lat, 1 + cyc);
    chk({tag, ".nobv"}, bus_valid, 0);
    flush_request = 1'b0;
    chk_ops(tag);
    @(negedge clock);
    chk({tag, ".pulse"}, flush_done, 0);
    if (with_bus) begin
      model_access(1'b0, addr, '0, rd, words);
      wait_for(1'b0, lat);
      chk({tag, ".blat"}, lat, 2 + words * (2 + stall_extra));
      chk({tag, ".brdata"}, bus_rdata, rd);
      bus_request = 1'b0;
      chk_ops({tag, ".bus"});
      last_words = words;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus_request = 1'b0; flush_request = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset(); clear_q();
  endtask

  initial begin : main
    int k, r;
    for (int i = 0; i < 16384; i++) begin nmem[i] = $urandom; rmem[i] = nmem[i]; end
    model_reset();
    #1;
    chk("rst.bus_valid", bus_valid, 0);
    chk("rst.flush_done", flush_done, 0);
    chk("rst.nl_request", nl_request, 0);
    chk("rst.nl_write", nl_write, 0);
    chk("rst.bus_rdata", bus_rdata, 0);
    chk("rst.nl_addr", nl_addr, 0);
    chk("rst.nl_wdata", nl_wdata, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // cold read accepted in the first IDLE cycle, then a re-read hit
    access("cold", 1'b0, 16'h0004, '0, 1'b1);
    access("rehit", 1'b0, 16'h0004, '0, 1'b0);
    chk("rehit.words", last_words, 0);
    @(negedge clock);
    chk("rehit.pulse", bus_valid, 0);

    // write hit, then eviction of the dirty 0x0000 line
    access("wrhit", 1'b1, 16'h0008, 32'hDEADBEEF, 1'b0);
    access("rd40", 1'b0, 16'h0040, '0, 1'b0);
    access("evict", 1'b0, 16'h0080, '0, 1'b0);
    chk("evict.words", last_words, 8);
    chk("evict.mem", nmem[2], 32'hDEADBEEF);

    // LRU: touching 0x0000 makes 0x0040 the victim
    do_reset();
    access("lru0", 1'b0, 16'h0000, '0, 1'b0);
    access("lru40", 1'b0, 16'h0040, '0, 1'b0);
    access("lru0b", 1'b0, 16'h0000, '0, 1'b0);
    access("lru80", 1'b0, 16'h0080, '0, 1'b0);
    access("lrukeep", 1'b0, 16'h0000, '0, 1'b0);
    chk("lrukeep.hit", last_words, 0);

    // flush wins over a simultaneous bus request
    do_reset();
    access("fw10", 1'b1, 16'h0010, 32'h1111_0010, 1'b0);
    access("fw30", 1'b1, 16'h0030, 32'h3333_0030, 1'b0);
    flush("flush", 1'b1, 16'h0010);
    chk("flush.hit", last_words, 0);
    chk("flush.mem10", nmem[16'h0010 >> 2], 32'h1111_0010);
    chk("flush.mem30", nmem[16'h0030 >> 2], 32'h3333_0030);

    // stalled next level, including a dirty writeback
    stall_extra = 5;
    k = stab_err;
    access("st50", 1'b0, 16'h0050, '0, 1'b0);
    access("stw50", 1'b1, 16'h0054, 32'hCAFE_0054, 1'b0);
    access("st10", 1'b0, 16'h0010, '0, 1'b0);
    access("st90", 1'b0, 16'h0090, '0, 1'b0);
    chk("stall.wb", last_words, 8);
    chk("stall.stable", stab_err - k, 0);
    stall_extra = 0;

    // reset in the middle of a fill
    @(negedge clock);
    bus_request = 1'b1; bus_write = 1'b0; bus_addr = 16'h0100;
    k = 0;
    while (act_a.size() < 2 && k < 200) begin @(negedge clock); k++; end
    chk("rstfill.reach", k < 200, 1);
    @(posedge clock); #1;
    reset = 1'b1; bus_request = 1'b0;
    #1;
    chk("rstfill.nlreq", nl_request, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset(); clear_q();
    access("refill", 1'b0, 16'h0100, '0, 1'b1);
    chk("refill.words", last_words, 4);

    // random traffic with byte-offset noise and small stalls
    for (int i = 0; i < 300 && n_fail < 50; i++) begin
      r = $urandom_range(0, 99);
      stall_extra = $urandom_range(0, 2);
      if (r < 8) flush("rflush", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)));
      else access("rnd", r < 50, 16'($urandom_range(0, 255)), $urandom, 1'b0);
    end
    chk("stable.all", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The block SHALL take these parameters:
- SETS, 16: number of sets, power of two, at least 2.
- WAYS, 2: ways per set, power of two, at least 2.
- LINEWORDS, 4: words per line, power of two, at least 2.
- WORDWIDTH, 32: word width in bits, a multiple of 8.
- ADDRWIDTH, 32: byte address width.
REQ-002 The block SHALL have these ports, clock and reset first:
- clock, in, 1: the single clock. All state changes on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- bus_request, in, 1: CPU access request. Held until bus_valid.
- bus_write, in, 1: 1 = write, 0 = read.
- bus_addr, in, ADDRWIDTH: byte address. Low log2(WORDWIDTH/8) bits are ignored.
- bus_wdata, in, WORDWIDTH: write data.
- bus_rdata, out, WORDWIDTH: read data. Meaningful only while bus_valid is high.
- bus_valid, out, 1: one-cycle completion pulse.
- flush_request, in, 1: write back all dirty lines. Held until flush_done.
- flush_done, out, 1: one-cycle flush completion pulse.
- nl_request, out, 1: next-level single-word transfer request.
- nl_write, out, 1: 1 = writeback word, 0 = fill word.
- nl_addr, out, ADDRWIDTH: word-aligned byte address. Byte bits are 0.
- nl_wdata, out, WORDWIDTH: writeback data.
- nl_rdata, in, WORDWIDTH: fill data. Sampled while nl_valid is high.
- nl_valid, in, 1: next-level completion of the current word.

Function
REQ-003 The address SHALL split, MSB to LSB, into tag, set (log2 SETS), word (log2 LINEWORDS) and byte (log2 WORDWIDTH/8) fields; the tag is the remaining bits.
REQ-004 Each way SHALL hold a valid bit, a dirty bit, a tag, LINEWORDS data words and a log2(WAYS)-bit age; age 0 is most recently used.
REQ-005 The state machine SHALL have the states IDLE, LOOKUP, WRITEBACK, FILL, RESPOND and FLUSH.
REQ-006 In IDLE:
- flush_request goes to FLUSH; it has priority over bus_request in the same cycle.
- Otherwise bus_request goes to LOOKUP.
- Otherwise the block stays in IDLE.
- The bus address, write flag and data SHALL be captured when leaving IDLE for LOOKUP.
REQ-007 In LOOKUP, a hit is a valid way whose tag matches; a hit SHALL go to RESPOND.
REQ-008 On a miss, the victim SHALL be the lowest-index invalid way; if every way is valid, the victim is the way whose age equals WAYS-1.
REQ-009 From LOOKUP on a miss, the block SHALL go to WRITEBACK if the victim is valid and dirty, otherwise to FILL.
REQ-010 WRITEBACK SHALL issue LINEWORDS write transfers of the victim line, word 0 first, with nl_addr = {victim tag, set, word, zeros}; it then goes to FILL.
REQ-011 FILL SHALL issue LINEWORDS read transfers, word 0 first, into the victim way. After the last word the way becomes valid, clean and tagged with the new tag, and the block goes to RESPOND.
REQ-012 Next-level handshake:
- nl_request, nl_write, nl_addr and nl_wdata SHALL be held stable until the cycle nl_valid is sampled high.
- The next word's request SHALL start in the following cycle.
- nl_valid while nl_request is low SHALL be ignored.
REQ-013 In RESPOND, the block SHALL assert bus_valid for exactly one cycle, then go to IDLE.
- Read: bus_rdata = the addressed word.
- Write: the word is written at the clock edge ending RESPOND and the dirty bit is set.
REQ-014 Hit latency SHALL be 2 cycles: bus_request is sampled in IDLE in cycle N, bus_valid is high in cycle N+2.
REQ-015 Miss latency SHALL be the hit latency plus the number of transfer cycles.
REQ-016 In RESPOND, the accessed way's age SHALL become 0. Every way in the set whose age was below the accessed way's old age SHALL be incremented, saturating at WAYS-1. Ages stay a permutation of 0..WAYS-1.
REQ-017 FLUSH SHALL visit set 0 to SETS-1 and, within each set, way 0 to WAYS-1.
- Each valid dirty way is written back per REQ-010 and its dirty bit cleared; valid bits are unchanged.
- Clean or invalid ways cost 1 cycle each.
- flush_done SHALL pulse in the cycle after the last visit, then the block returns to IDLE.
REQ-018 bus_request and flush_request SHALL be ignored outside IDLE; a request held until service is served in the next IDLE.
REQ-019 bus_valid and flush_done SHALL never be high in the same cycle.

Reset
REQ-020 While reset is high:
- All valid and dirty bits SHALL be 0.
- Way i's age SHALL be i in every set.
- The state SHALL be IDLE.
- bus_valid, flush_done, nl_request and nl_write SHALL be 0; bus_rdata, nl_addr and nl_wdata SHALL be all zeros.
REQ-021 Reset asserted mid-WRITEBACK, mid-FILL or mid-FLUSH SHALL abandon the transfer with no further nl_request. Dirty data is lost, by design.
REQ-022 The first request SHALL be accepted in the first IDLE cycle after reset deasserts.

Verification
Configuration for all scenarios: SETS=4, WAYS=2, LINEWORDS=4, WORDWIDTH=32, ADDRWIDTH=16; the next level answers nl_valid 1 cycle after nl_request.
REQ-023 Cold read: read 0x0004 after reset -> 4 fill reads at nl_addr 0x0000, 0x0004, 0x0008, 0x000C; bus_rdata = memory[0x0004]. An immediate re-read hits with bus_valid at cycle N+2 and no nl_request.
REQ-024 Write hit, then eviction:
- Stimulus: write 0xDEADBEEF to 0x0008, then read 0x0040 and then 0x0080 (both map to set 0).
- The 0x0080 miss evicts LRU line 0x0000 (dirty): 4 writebacks with nl_addr 0x0000-0x000C, the word at 0x0008 = 0xDEADBEEF.
- Then 4 fills from 0x0080.
REQ-025 LRU order: fill 0x0000 and 0x0040, re-read 0x0000, then miss on 0x0080 -> the victim is the 0x0040 line; 0x0000 still hits.
REQ-026 Flush: lines 0x0010 and 0x0030 dirty; flush_request together with bus_request -> flush wins; 8 writes occur at 0x0010-0x001C and 0x0030-0x003C; flush_done pulses once; a re-read of 0x0010 hits.
REQ-027 Reset mid-FILL: assert reset after the 2nd fill word -> nl_request is 0 immediately; a subsequent read of the same address misses and performs 4 fills.
REQ-028 Stalled next level: hold nl_valid low for 5 cycles -> nl_addr and nl_wdata are stable throughout, and no bus_valid occurs.
